// File: rtl/conv_strip_engine.sv
`default_nettype none
// ============================================================================
// Module      : conv_strip_engine
// Description : Strip convolver. Holds a K-column window and produces NB_LANES
//               output pixels per column through a 3-stage MAC pipeline, using
//               a run-time kernel bank with a per-strip snapshot.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_strip_engine #(
    parameter int IMAGE_WIDTH  = 200,
    parameter int KERNEL_WIDTH = 3,
    parameter int NB_PIXEL     = 8,
    parameter int NB_COEFF     = 8,
    parameter int NB_LANES     = 4,
    parameter int NUM_KERNELS  = 4,
    parameter int NB_SHIFT     = 4
) (
    input  logic                                          i_clk,
    input  logic                                          i_reset,
    input  logic [(NB_LANES+KERNEL_WIDTH-1)*NB_PIXEL-1:0] i_data,
    input  logic                                          i_valid,
    input  logic [$clog2(NUM_KERNELS)-1:0]                i_kernel_sel,
    input  logic                                          i_cfg_we,
    input  logic [$clog2(NUM_KERNELS)-1:0]                i_cfg_kernel,
    input  logic [$clog2(KERNEL_WIDTH*KERNEL_WIDTH+1)-1:0] i_cfg_addr,
    input  logic [NB_COEFF-1:0]                           i_cfg_data,
    output logic [NB_LANES*NB_PIXEL-1:0]                  o_data,
    output logic                                          o_valid,
    output logic                                          o_last,
    output logic [$clog2(NUM_KERNELS)-1:0]                o_active_kernel
);

    localparam int c_K      = KERNEL_WIDTH;
    localparam int c_TAPS   = c_K * c_K;
    localparam int c_SEG    = NB_LANES + c_K - 1;
    localparam int c_CENTRE = (c_TAPS - 1) / 2;
    localparam int c_KSEL_W = $clog2(NUM_KERNELS);
    localparam int c_ADDR_W = $clog2(c_TAPS + 1);
    localparam int c_CNT_W  = $clog2(IMAGE_WIDTH);
    localparam int c_ACC_W  = NB_PIXEL + NB_COEFF + $clog2(c_TAPS) + 1;

    localparam logic [c_KSEL_W:0]   c_NUMK      = (c_KSEL_W+1)'(NUM_KERNELS);
    localparam logic [c_ADDR_W-1:0] c_TAPS_A    = c_ADDR_W'(c_TAPS);
    localparam logic [c_CNT_W-1:0]  c_FIRST_COL = c_CNT_W'(c_K - 1);
    localparam logic [c_CNT_W-1:0]  c_LAST_COL  = c_CNT_W'(IMAGE_WIDTH - 1);

    logic [c_CNT_W-1:0]         r_col_cnt;
    logic [NB_PIXEL-1:0]        r_win [c_K][c_SEG];
    logic signed [NB_COEFF-1:0] r_bank_coef [NUM_KERNELS][c_TAPS];
    logic [NB_SHIFT-1:0]        r_bank_shift [NUM_KERNELS];
    logic signed [NB_COEFF-1:0] r_act_coef [c_TAPS];
    logic [NB_SHIFT-1:0]        r_act_shift;

    logic signed [c_ACC_W-1:0]  r_prod [NB_LANES][c_TAPS];
    logic signed [c_ACC_W-1:0]  r_sum [NB_LANES];
    logic                       r_s1_valid, r_s1_last, r_s2_valid, r_s2_last;
    logic [NB_SHIFT-1:0]        r_s1_shift, r_s2_shift;

    logic                       w_strip_start;
    logic [c_KSEL_W-1:0]        w_sel;
    logic [NB_PIXEL-1:0]        w_col_pix [c_K][c_SEG];
    logic signed [NB_COEFF-1:0] w_coef [c_TAPS];
    logic [NB_SHIFT-1:0]        w_shift;
    logic signed [c_ACC_W-1:0]  w_prod [NB_LANES][c_TAPS];
    logic signed [c_ACC_W-1:0]  w_sum [NB_LANES];
    logic signed [c_ACC_W-1:0]  w_shifted [NB_LANES];
    logic [NB_LANES*NB_PIXEL-1:0] w_sat;

    assign w_strip_start = i_valid && (r_col_cnt == '0);
    assign w_sel         = ({1'b0, i_kernel_sel} < c_NUMK) ? i_kernel_sel : '0;

    // Window as it will look once this beat is accepted; stage 1 works on it
    // directly so products register on the acceptance edge.
    for (genvar c = 0; c < c_K - 1; c++) begin : g_shift_col
        for (genvar p = 0; p < c_SEG; p++) begin : g_shift_pix
            assign w_col_pix[c][p] = r_win[c+1][p];
        end
    end
    for (genvar p = 0; p < c_SEG; p++) begin : g_new_pix
        assign w_col_pix[c_K-1][p] = i_data[p*NB_PIXEL +: NB_PIXEL];
    end

    // A strip-start beat must already use the kernel being snapshotted.
    always_comb begin
        for (int t = 0; t < c_TAPS; t++) begin
            w_coef[t] = w_strip_start ? r_bank_coef[w_sel][t] : r_act_coef[t];
        end
        w_shift = w_strip_start ? r_bank_shift[w_sel] : r_act_shift;
    end

    for (genvar l = 0; l < NB_LANES; l++) begin : g_lane
        for (genvar t = 0; t < c_TAPS; t++) begin : g_tap
            localparam int c_ROW = t / c_K;
            localparam int c_COL = t % c_K;
            logic signed [c_ACC_W-1:0] w_px;
            logic signed [c_ACC_W-1:0] w_cf;
            assign w_px        = c_ACC_W'($signed({1'b0, w_col_pix[c_COL][l+c_ROW]}));
            assign w_cf        = c_ACC_W'(w_coef[t]);
            assign w_prod[l][t] = w_px * w_cf;
        end
    end

    always_comb begin
        w_sat = '0;
        for (int l = 0; l < NB_LANES; l++) begin
            w_sum[l] = '0;
            for (int t = 0; t < c_TAPS; t++) begin
                w_sum[l] = w_sum[l] + r_prod[l][t];
            end
            w_shifted[l] = r_sum[l] >>> r_s2_shift;
            if (w_shifted[l][c_ACC_W-1]) begin
                w_sat[l*NB_PIXEL +: NB_PIXEL] = '0;
            end else if (|w_shifted[l][c_ACC_W-2:NB_PIXEL]) begin
                w_sat[l*NB_PIXEL +: NB_PIXEL] = '1;
            end else begin
                w_sat[l*NB_PIXEL +: NB_PIXEL] = w_shifted[l][NB_PIXEL-1:0];
            end
        end
    end

    // Kernel bank: reset loads identity kernels; a snapshot on the same edge
    // as a write sees the pre-write contents.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < NUM_KERNELS; k++) begin
                for (int t = 0; t < c_TAPS; t++) begin
                    r_bank_coef[k][t] <= (t == c_CENTRE) ? NB_COEFF'(1) : '0;
                end
                r_bank_shift[k] <= '0;
            end
        end else if (i_cfg_we && ({1'b0, i_cfg_kernel} < c_NUMK)) begin
            if (i_cfg_addr < c_TAPS_A) begin
                r_bank_coef[i_cfg_kernel][i_cfg_addr] <= i_cfg_data;
            end else if (i_cfg_addr == c_TAPS_A) begin
                r_bank_shift[i_cfg_kernel] <= i_cfg_data[NB_SHIFT-1:0];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        r_prod     <= w_prod;
        r_sum      <= w_sum;
        r_s1_shift <= w_shift;
        r_s2_shift <= r_s1_shift;
        r_s1_last  <= i_valid && (r_col_cnt == c_LAST_COL);
        r_s2_last  <= r_s1_last;
        if (i_reset) begin
            r_col_cnt       <= '0;
            r_s1_valid      <= 1'b0;
            r_s2_valid      <= 1'b0;
            o_valid         <= 1'b0;
            o_last          <= 1'b0;
            o_data          <= '0;
            o_active_kernel <= '0;
            r_act_shift     <= '0;
            for (int c = 0; c < c_K; c++) begin
                for (int p = 0; p < c_SEG; p++) begin
                    r_win[c][p] <= '0;
                end
            end
            for (int t = 0; t < c_TAPS; t++) begin
                r_act_coef[t] <= (t == c_CENTRE) ? NB_COEFF'(1) : '0;
            end
        end else begin
            r_s1_valid <= i_valid && (r_col_cnt >= c_FIRST_COL);
            r_s2_valid <= r_s1_valid;
            o_valid    <= r_s2_valid;
            o_last     <= r_s2_valid && r_s2_last;
            if (r_s2_valid) begin
                o_data <= w_sat;
            end
            if (i_valid) begin
                r_win     <= w_col_pix;
                r_col_cnt <= (r_col_cnt == c_LAST_COL) ? '0 : r_col_cnt + 1'b1;
            end
            if (w_strip_start) begin
                r_act_coef      <= w_coef;
                r_act_shift     <= w_shift;
                o_active_kernel <= w_sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_strip_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_strip_engine
// Description : Directed self-checking bench for conv_strip_engine (8-column
//               strips, 3x3 kernels, 3-entry bank).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_strip_engine;

    localparam int c_IW  = 8;
    localparam int c_K   = 3;
    localparam int c_NL  = 4;
    localparam int c_NK  = 3;
    localparam int c_SEG = c_NL + c_K - 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [c_SEG*8-1:0]    data;
    logic                  valid;
    logic [1:0]            ksel;
    logic                  cfg_we;
    logic [1:0]            cfg_k;
    logic [3:0]            cfg_addr;
    logic [7:0]            cfg_data;
    logic [c_NL*8-1:0]     o_data;
    logic                  o_valid;
    logic                  o_last;
    logic [1:0]            o_ak;

    conv_strip_engine #(
        .IMAGE_WIDTH (c_IW),
        .KERNEL_WIDTH(c_K),
        .NB_PIXEL    (8),
        .NB_COEFF    (8),
        .NB_LANES    (c_NL),
        .NUM_KERNELS (c_NK),
        .NB_SHIFT    (4)
    ) u_dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_data         (data),
        .i_valid        (valid),
        .i_kernel_sel   (ksel),
        .i_cfg_we       (cfg_we),
        .i_cfg_kernel   (cfg_k),
        .i_cfg_addr     (cfg_addr),
        .i_cfg_data     (cfg_data),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .o_last         (o_last),
        .o_active_kernel(o_ak)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] q_data[$];
    logic        q_last[$];
    logic [1:0]  q_k[$];
    int          q_cyc[$];
    int          beat_cyc[$];
    logic [31:0] exp_q[$];

    always @(negedge clk) begin
        if (o_valid) begin
            q_data.push_back(o_data);
            q_last.push_back(o_last);
            q_k.push_back(o_ak);
            q_cyc.push_back(cyc);
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [c_SEG*8-1:0] make_seg(input int mode, input logic [7:0] v, input int c);
        logic [c_SEG*8-1:0] s;
        s = '0;
        for (int p = 0; p < c_SEG; p++) begin
            case (mode)
                0:       s[p*8 +: 8] = 8'(c * 10 + p);
                1:       s[p*8 +: 8] = v;
                default: s[p*8 +: 8] = (c == 3 && p == 2) ? v : ~v;
            endcase
        end
        return s;
    endfunction

    // Lane l of output k: ramp pixel (k+row_off)*10 + l + pix_off
    function automatic logic [31:0] ramp_exp(input int col, input int pix_off);
        logic [31:0] r;
        for (int l = 0; l < c_NL; l++) r[l*8 +: 8] = 8'(col * 10 + l + pix_off);
        return r;
    endfunction

    task automatic beat(input logic [c_SEG*8-1:0] seg, input logic [1:0] sel, input bit mw);
        data  = seg;
        valid = 1'b1;
        ksel  = sel;
        if (mw) begin
            cfg_we   = 1'b1;
            cfg_k    = 2'd1;
            cfg_addr = 4'd4;
            cfg_data = 8'd20;
        end
        beat_cyc.push_back(cyc);
        @(negedge clk);
        valid  = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic run_strip(input int mode, input logic [7:0] v, input logic [1:0] sel,
                             input int gap, input bit midw);
        for (int j = 0; j < c_IW; j++) begin
            beat(make_seg(mode, v, j), sel, midw && (j == 3));
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic cfg_write(input logic [1:0] k, input logic [3:0] a, input logic [7:0] d);
        cfg_we   = 1'b1;
        cfg_k    = k;
        cfg_addr = a;
        cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic load_kernel(input logic [1:0] k, input int taps[9], input int shift);
        for (int t = 0; t < 9; t++) cfg_write(k, 4'(t), 8'(taps[t]));
        cfg_write(k, 4'd9, 8'(shift));
    endtask

    // Waits (bounded) for the expected outputs, then checks data/last/kernel
    // and optionally the 3-cycle latency against the beat that produced each.
    task automatic check_outputs(input string name, input logic [1:0] kern, input bit lat);
        int n;
        int budget;
        n = exp_q.size();
        budget = 300;
        while (q_data.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        repeat (4) @(negedge clk);
        check($sformatf("%s_count", name), 64'(q_data.size()), 64'(n));
        for (int k = 0; k < n; k++) begin
            if (k < q_data.size()) begin
                check($sformatf("%s_data[%0d]", name, k), 64'(q_data[k]), 64'(exp_q[k]));
                check($sformatf("%s_last[%0d]", name, k), 64'(q_last[k]), 64'(k % 6 == 5));
                check($sformatf("%s_kern[%0d]", name, k), 64'(q_k[k]), 64'(kern));
                if (lat)
                    check($sformatf("%s_lat[%0d]", name, k),
                          64'(q_cyc[k] - beat_cyc[(k / 6) * 8 + k % 6 + 2]), 64'd3);
            end
        end
        q_data.delete(); q_last.delete(); q_k.delete(); q_cyc.delete();
        beat_cyc.delete(); exp_q.delete();
    endtask

    int gauss[9]  = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    int border[9] = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
    int topnew[9] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};

    initial begin
        rst = 1'b1; data = '0; valid = 1'b0; ksel = '0;
        cfg_we = 1'b0; cfg_k = '0; cfg_addr = '0; cfg_data = '0;
        repeat (3) @(negedge clk);
        check("reset_valid", 64'(o_valid), 64'd0);
        check("reset_last",  64'(o_last),  64'd0);
        check("reset_data",  64'(o_data),  64'd0);
        check("reset_kern",  64'(o_ak),    64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Identity kernel on a ramp: output = centre pixel of each lane window.
        run_strip(0, 8'd0, 2'd0, 0, 1'b0);
        for (int k = 0; k < 6; k++) exp_q.push_back(ramp_exp(k + 1, 1));
        check_outputs("ident", 2'd0, 1'b1);

        load_kernel(2'd1, gauss, 4);
        run_strip(1, 8'd100, 2'd1, 0, 1'b0);
        for (int k = 0; k < 6; k++) exp_q.push_back(32'h64646464);
        check_outputs("gauss", 2'd1, 1'b0);

        load_kernel(2'd2, border, 0);
        run_strip(1, 8'd50, 2'd2, 0, 1'b0);
        for (int k = 0; k < 6; k++) exp_q.push_back(32'h0);
        check_outputs("border_flat", 2'd2, 1'b0);

        run_strip(2, 8'd255, 2'd2, 0, 1'b0);
        exp_q = '{32'h0, 32'h0, 32'h0000FF00, 32'h0, 32'h0, 32'h0};
        check_outputs("border_peak", 2'd2, 1'b0);

        run_strip(2, 8'd0, 2'd2, 0, 1'b0);
        exp_q = '{32'h0, 32'h00FFFFFF, 32'h00FF00FF, 32'h00FFFFFF, 32'h0, 32'h0};
        check_outputs("border_hole", 2'd2, 1'b0);

        // Mid-strip centre-tap rewrite, then a back-to-back strip.
        run_strip(1, 8'd100, 2'd1, 0, 1'b1);
        run_strip(1, 8'd100, 2'd1, 0, 1'b0);
        for (int k = 0; k < 6; k++) exp_q.push_back(32'h64646464);
        for (int k = 0; k < 6; k++) exp_q.push_back(32'hC8C8C8C8);
        check_outputs("midwrite", 2'd1, 1'b1);

        // Reset on beat 4 of a strip.
        for (int j = 0; j < 4; j++) beat(make_seg(0, 8'd0, j), 2'd2, 1'b0);
        rst   = 1'b1;
        valid = 1'b1;
        data  = make_seg(0, 8'd0, 4);
        @(negedge clk);
        check("midrst_valid", 64'(o_valid), 64'd0);
        rst   = 1'b0;
        valid = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_stale", 64'(q_data.size()), 64'd0);
        check("midrst_data",  64'(o_data), 64'd0);
        check("midrst_kern",  64'(o_ak),   64'd0);
        q_data.delete(); q_last.delete(); q_k.delete(); q_cyc.delete(); beat_cyc.delete();
        run_strip(0, 8'd0, 2'd1, 0, 1'b0);
        for (int k = 0; k < 6; k++) exp_q.push_back(ramp_exp(k + 1, 1));
        check_outputs("postrst", 2'd1, 1'b1);

        // Out-of-range select falls back to kernel 0; gapped input.
        load_kernel(2'd0, topnew, 0);
        run_strip(0, 8'd0, 2'd3, 2, 1'b0);
        for (int k = 0; k < 6; k++) exp_q.push_back(ramp_exp(k + 2, 0));
        check_outputs("gapped", 2'd0, 1'b1);
        check("hold_valid", 64'(o_valid), 64'd0);
        check("hold_data",  64'(o_data),  64'(ramp_exp(7, 0)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/conv_strip_engine.md
Name: conv_strip_engine

Overview:
- Parametrised successor to the fixed four-lane convolver top.
- Accepts one image column segment per valid beat and keeps the last KERNEL_WIDTH columns in a window register.
- Computes NB_LANES vertically adjacent output pixels per column through a 3-stage MAC pipeline.
- Kernels are loaded at run time into a NUM_KERNELS bank, with per-kernel right-shift scaling and saturation. The active kernel is snapshotted at each strip start; the block emits valid/last framing.

Parameters:
IMAGE_WIDTH, 200, columns per strip (including padding)
KERNEL_WIDTH, 3, kernel side K (odd, >=3)
NB_PIXEL, 8, unsigned pixel width
NB_COEFF, 8, signed coefficient width
NB_LANES, 4, output pixels per beat
NUM_KERNELS, 4, kernel bank depth
NB_SHIFT, 4, used bits of the per-kernel shift entry

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_data  in  (NB_LANES+K-1)*NB_PIXEL  column segment; pixel p at [p*NB_PIXEL +: NB_PIXEL], p=0 top
i_valid  in  1  segment valid (no backpressure)
i_kernel_sel  in  clog2(NUM_KERNELS)  requested kernel for next strip
i_cfg_we  in  1  bank write strobe
i_cfg_kernel  in  clog2(NUM_KERNELS)  bank entry written
i_cfg_addr  in  clog2(K*K+1)  0..K*K-1 = tap, K*K = shift
i_cfg_data  in  NB_COEFF  coefficient, or shift in low NB_SHIFT bits
o_data  out  NB_LANES*NB_PIXEL  lane l at [l*NB_PIXEL +: NB_PIXEL]
o_valid  out  1  o_data valid
o_last  out  1  with o_valid: final output of strip
o_active_kernel  out  clog2(NUM_KERNELS)  kernel used by current strip

Behaviour:
- Reset (any cycle, including mid-strip):
  - col_cnt=0; window and pipeline valids cleared.
  - o_valid=0, o_last=0, o_data=0, o_active_kernel=0.
  - Every bank entry becomes identity: centre tap ((K*K-1)/2) = 1, other taps 0, shift 0.
- Column counter:
  - Increments on each i_valid beat.
  - Wraps IMAGE_WIDTH-1 -> 0; no change when i_valid=0.
- Window:
  - On i_valid, the window shifts by one column; the new segment becomes column K-1 (newest), and column 0 is the oldest.
  - Window contents are not cleared between strips.
- Strip start (i_valid with col_cnt==0):
  - The active kernel register copies bank[i_kernel_sel] (K*K taps + shift); o_active_kernel is updated.
  - If i_kernel_sel >= NUM_KERNELS, kernel 0 is used.
- Cfg writes:
  - Take effect in the bank on the next cycle; they never alter the active copy.
  - A write during a strip therefore affects only later strips.
  - A write coinciding with a strip-start snapshot of the same entry: the snapshot takes the old value.
  - Writes with out-of-range kernel or addr are ignored.
- Tap mapping: tap t = row*K + col, where row 0 is the topmost pixel of the lane window and col 0 is the oldest column.
  - Lane l uses segment pixels l..l+K-1.
- Arithmetic:
  - Accumulator is signed, width NB_PIXEL+NB_COEFF+clog2(K*K)+1; pixels are zero-extended.
  - Sum is arithmetic right-shifted by the shift value (floor, no rounding).
  - Result is saturated to [0, 2^NB_PIXEL-1].
- Pipeline:
  - Stage 1: products. Stage 2: adder tree. Stage 3: shift + saturate.
  - Output appears exactly 3 cycles after the accepted beat, independent of later i_valid gaps.
- Output gating:
  - A beat produces an output only if it completes a full window, i.e. its col_cnt >= K-1 at acceptance.
  - This gives IMAGE_WIDTH-K+1 outputs per strip.
  - o_last accompanies the output of the beat with col_cnt == IMAGE_WIDTH-1.
- Output hold: o_data holds its last value when o_valid=0.
- Back-to-back strips run with no bubbles; the first K-1 beats of a new strip produce no output.

Test Plan:
- After reset, IMAGE_WIDTH=8, K=3; feed 8 beats of ramp columns -> 6 o_valid pulses, each o_data = centre pixels (identity), o_last on the 6th, first output 3 cycles after beat index 2.
- Load kernel 1 with gaussian [1 2 1;2 4 2;1 2 1] and shift 4, select 1; constant-100 strip -> all lanes 100.
- Load kernel 2 with border (-1 ring, centre 8), select 2:
  - Constant 50 -> 0.
  - Isolated 255 centre -> 255 (saturated).
  - Isolated 0 in a 255 field -> 0 (negative saturated).
- Rewrite a kernel-1 tap mid-strip while kernel 1 is active -> current strip output unchanged; next strip reflects the new tap; o_active_kernel stable within the strip.
- Assert reset at beat 4 of a strip -> o_valid low the next cycle, no stale output afterwards; the next strip restarts at col_cnt 0 with identity kernels.
- Gapped i_valid (one beat every 3 cycles) and i_kernel_sel=3 with NUM_KERNELS=3 -> outputs identical to a gapless run, using kernel 0.
